// File: rtl/phivers_input_buffer.sv
// Phivers router input port buffer: credit-returning flit FIFO with
// packet framing tracking and optional store-and-forward release.
module phivers_input_buffer #(
   parameter int unsigned BUFFER_DEPTH = 8,
   parameter bit          CUT_THROUGH  = 1'b1
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            rx_i,
   output logic                            cr_rx_o,
   input  logic                            eop_rx_i,
   input  logic [31:0]                     data_rx_i,
   output logic                            tx_o,
   input  logic                            cr_tx_i,
   output logic                            eop_tx_o,
   output logic [31:0]                     data_tx_o,
   output logic                            hdr_o,
   output logic [$clog2(BUFFER_DEPTH):0]   occupancy_o,
   output logic [$clog2(BUFFER_DEPTH):0]   pkt_cnt_o,
   output logic                            overflow_o
);

   localparam int unsigned AW = $clog2(BUFFER_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_DEPTH);

   typedef enum logic {
      HEAD = 1'b0,
      BODY = 1'b1
   } frame_t;

   logic [32:0]   mem [BUFFER_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] occ;
   logic [CW-1:0] pkt_cnt;
   logic          overflow;
   frame_t        state_q;
   frame_t        state_d;

   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [32:0]   head;

   assign full    = (occ == FULL_CNT);
   assign empty   = (occ == '0);
   assign head    = mem[rd_ptr];

   assign cr_rx_o = !full;
   assign push    = rx_i && !full;
   assign pop     = tx_o && cr_tx_i;

   // Store-and-forward falls back to cut-through when full so that
   // packets longer than the buffer cannot deadlock the port.
   generate
      if (CUT_THROUGH) begin : g_ct
         assign tx_o = !empty;
      end else begin : g_sf
         assign tx_o = !empty &&
                       (pkt_cnt != '0 || state_q == BODY || full);
      end
   endgenerate

   assign data_tx_o   = empty ? 32'h0 : head[31:0];
   assign eop_tx_o    = !empty && head[32];
   assign hdr_o       = tx_o && (state_q == HEAD);
   assign occupancy_o = occ;
   assign pkt_cnt_o   = pkt_cnt;
   assign overflow_o  = overflow;

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= {eop_rx_i, data_rx_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         pkt_cnt  <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
         unique case ({push && eop_rx_i, pop && eop_tx_o})
            2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
            2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
            default: pkt_cnt <= pkt_cnt;
         endcase
         if (rx_i && !cr_rx_o) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= HEAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (pop) begin
         unique case (state_q)
            HEAD:    state_d = eop_tx_o ? HEAD : BODY;
            BODY:    state_d = eop_tx_o ? HEAD : BODY;
            default: state_d = HEAD;
         endcase
      end
   end

endmodule

// File: doc/phivers_input_buffer.md
Name: phivers_input_buffer

Overview:
- Credit-based input FIFO for one Phivers router port, directly downstream of the per-port link stage.
- Captures flits (32-bit data plus end-of-packet flag) arriving from the link and returns credit to it.
- Presents flits to the router's routing/crossbar stage and tracks packet framing: header flag, count of complete packets stored.
- Optional store-and-forward mode holds a packet until its tail flit is buffered.

Parameters:
- BUFFER_DEPTH, 8, number of flit slots; power of two, >= 2.
- CUT_THROUGH, 1'b1, 1 = forward flits as soon as buffered; 0 = store-and-forward.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- rx_i  input  1  flit valid from link.
- cr_rx_o  output  1  credit (ready) to link; a flit is accepted when rx_i && cr_rx_o.
- eop_rx_i  input  1  incoming flit is the last of its packet.
- data_rx_i  input  32  incoming flit data.
- tx_o  output  1  flit available to router.
- cr_tx_i  input  1  router accepts; pop when tx_o && cr_tx_i.
- eop_tx_o  output  1  head flit is end of packet.
- data_tx_o  output  32  head flit data.
- hdr_o  output  1  head flit is a packet header (first flit).
- occupancy_o  output  $clog2(BUFFER_DEPTH)+1  flits stored.
- pkt_cnt_o  output  $clog2(BUFFER_DEPTH)+1  complete packets (eop flits) stored.
- overflow_o  output  1  sticky protocol-violation flag.

Behaviour:
- Clock and reset: single clock, clk_i. Reset is synchronous and active-high on rst_i; it is sampled only at the clk_i rising edge.
- Reset values: pointers, occupancy, pkt_cnt and overflow are all 0; the output state is HEAD.
  - Post-reset outputs: cr_rx_o=1, tx_o=0, hdr_o=0, eop_tx_o=0, data_tx_o=0.
- Reset mid-packet discards all stored flits. The next accepted flit is treated as a header.
- Storage: circular buffer of BUFFER_DEPTH entries of {eop, data}.
  - Write and read pointers wrap modulo BUFFER_DEPTH.
  - occupancy counts 0..BUFFER_DEPTH.
- Credit: cr_rx_o = (occupancy != BUFFER_DEPTH), derived from registered state only. There is no full-bypass.
  - When full, a simultaneous pop does not raise cr_rx_o in the same cycle; it rises the following cycle.
- Latency: a flit accepted at edge N is visible on tx_o/data_tx_o after edge N. There is no empty-bypass.
- Head outputs: data_tx_o and eop_tx_o come from the read-pointer entry. Both are 0 when empty.
- Simultaneous push and pop (non-full, non-empty): occupancy unchanged, both pointers advance.
- pkt_cnt rules:
  - +1 on a push with eop_rx_i=1.
  - -1 on a pop with eop_tx_o=1.
  - Unchanged when both happen in the same cycle.
- Output framing FSM:
  - States: HEAD (next flit out is a header) and BODY.
  - HEAD -> BODY on a pop with eop_tx_o=0.
  - BODY -> HEAD on a pop with eop_tx_o=1.
  - A single-flit packet (header with eop) pops HEAD -> HEAD.
  - hdr_o = tx_o && state==HEAD.
- tx_o, cut-through (CUT_THROUGH=1): tx_o = occupancy != 0.
- tx_o, store-and-forward (CUT_THROUGH=0): tx_o = (occupancy != 0) && (pkt_cnt != 0 || state==BODY || occupancy==BUFFER_DEPTH).
  - A packet longer than the buffer therefore falls back to cut-through when full, which avoids deadlock.
  - Once the fallback starts (state BODY), that packet keeps forwarding until its eop.
- tx_o withdrawal: tx_o never deasserts while data is held without a pop, except on reset.
- Overflow: rx_i=1 while cr_rx_o=0 drops the flit; storage and pkt_cnt are unchanged.
  - overflow_o is set on the next edge and held until reset.
- Timing: no combinational path from rx_i/cr_tx_i to cr_rx_o or tx_o.

Test Plan:
- Reset, then push one flit {eop=1, data=32'h0000_0102} → tx_o=1, hdr_o=1, eop_tx_o=1 one cycle later; pop → tx_o=0, pkt_cnt_o=0, FSM in HEAD.
- Fill BUFFER_DEPTH=8 with cr_tx_i=0 → cr_rx_o=0 after the 8th accept, occupancy_o=8. Pop and push in the same cycle while full → only the pop happens; cr_rx_o=1 next cycle; occupancy_o=7.
- Stream a 3-flit packet then a 2-flit packet, with cr_tx_i toggled every cycle → output order identical; hdr_o=1 only on flit 0 and flit 3; pkt_cnt_o peaks at 2 and returns to 0.
- CUT_THROUGH=0, push a 4-flit packet one flit per cycle → tx_o stays 0 until the cycle after the eop flit is written. A 10-flit packet into depth 8 → tx_o rises when occupancy_o=8 and all 10 flits drain in order.
- Drive rx_i=1 while full → flit discarded, occupancy_o stays 8, overflow_o=1 persistently. Assert rst_i → all outputs return to reset values and cr_rx_o=1.
- Assert rst_i after 2 of 3 flits are stored → occupancy_o=0. Next flit {eop=0, 32'hCAFE0000} is presented with hdr_o=1.
